// File: rtl/nubus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nubus_arbiter
// Purpose  : Distributed NuBus arbitration contender. Drives the open-collector
//            /RQST and /ARB<3:0> lines from the card's slot ID and resolves the
//            bitwise priority contest. It hands arb_grant to the master
//            controller once the sampled /ARB value has held the card's own ID
//            for SETTLE_CYCLES consecutive clocks.
// Options  : NUBUS_ARB_FAIRNESS_EN - when defined, the card waits in FAIR after
//            its tenure until /RQST is seen released. fair_hold reports this.
// Revision : 1.0 - initial release
// ============================================================================
module nubus_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..7
) (
  input  logic       nub_clkn,
  input  logic       nub_resetn,
  input  logic [3:0] nub_idn,
  input  logic [3:0] nub_arbn,
  input  logic       nub_rqstn,
  input  logic       arbcy,
  input  logic       adrcy,
  output logic [3:0] arb_oe,
  output logic       rqst_oe,
  output logic       arb_grant,
  output logic       fair_hold
);

  // Settle target in counter width; the counter saturates at CNT_MAX.
  localparam logic [2:0] SETTLE_TARGET = 3'(SETTLE_CYCLES);
  localparam logic [2:0] CNT_MAX       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_GRANT = 3'd2,
    S_OWN   = 3'd3,
    S_FAIR  = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  state_t     release_state;   // where a finished tenure or grant goes

  logic [2:0] settle_q;
  logic [2:0] settle_d;
  logic [3:0] arb_prev_q;      // /ARB sample from the previous clock

  logic [3:0] id;
  logic [3:0] arb;
  logic [3:0] contend_oe;
  logic       arb_changed;
  logic       arb_is_id;
  logic       settled;

  // Backplane lines are active-low. Work internally in positive logic.
  assign id  = ~nub_idn;
  assign arb = ~nub_arbn;

  assign arb_changed = (arb != arb_prev_q);
  assign arb_is_id   = (arb == id);

  // Fairness option: the release target and the status flag.
`ifdef NUBUS_ARB_FAIRNESS_EN
  assign release_state = S_FAIR;
  assign fair_hold     = (state_q == S_FAIR);
`else
  assign release_state = S_IDLE;
  assign fair_hold     = 1'b0;
`endif

  // Bitwise contest. Bit i is driven only if no higher bit has been lost.
  // Bit j is lost when the bus shows 1 there while our ID bit j is 0.
  // The MSB is never preempted.
  assign contend_oe[3] = id[3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_contend
      assign contend_oe[gi] = id[gi] & (&(id[3:gi+1] | ~arb[3:gi+1]));
    end
  endgenerate

  // Settle counter next value. It clears outside ARB and on any bus change.
  // It counts while the bus shows our ID and saturates at CNT_MAX.
  always_comb begin
    settle_d = settle_q;
    if ((state_q != S_ARB) || arb_changed) begin
      settle_d = 3'd0;
    end else if (arb_is_id && (settle_q != CNT_MAX)) begin
      settle_d = settle_q + 3'd1;
    end
  end

  // The grant is taken on the same edge the counter reaches its target.
  assign settled = (state_q == S_ARB) && !arb_changed && arb_is_id &&
                   (settle_d >= SETTLE_TARGET);

  // Next-state and output decode. The outputs are Moore apart from the ARB
  // contest term, which also follows the sampled bus.
  always_comb begin
    state_d   = state_q;
    arb_oe    = 4'b0000;
    rqst_oe   = 1'b0;
    arb_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arbcy && !fair_hold) begin
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        rqst_oe = 1'b1;
        arb_oe  = contend_oe;
        // An abort before the grant does not count as a tenure.
        if (!arbcy) begin
          state_d = S_IDLE;
        end else if (settled) begin
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        arb_grant = 1'b1;
        rqst_oe   = 1'b1;
        arb_oe    = id;
        // A dropped arbcy wins over a same-cycle adrcy.
        if (!arbcy) begin
          state_d = release_state;
        end else if (adrcy) begin
          state_d = S_OWN;
        end
      end

      S_OWN: begin
        arb_grant = 1'b1;
        if (!arbcy) begin
          state_d = release_state;
        end
      end

      S_FAIR: begin
        // Stay off the bus until no other card is requesting.
        if (nub_rqstn) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, settle counter and previous-bus register, with synchronous reset.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_q    <= S_IDLE;
      settle_q   <= 3'd0;
      arb_prev_q <= 4'b0000;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      arb_prev_q <= arb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nubus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nubus_arbiter
// Purpose  : Self-checking bench for nubus_arbiter. It runs directed scenarios
//            and then randomized traffic. A phase-level reference model
//            predicts the outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nubus_arbiter;

  localparam int SETTLE = 2;
`ifdef NUBUS_ARB_FAIRNESS_EN
  localparam bit FAIR_ON = 1'b1;
`else
  localparam bit FAIR_ON = 1'b0;
`endif

  logic       nub_clkn = 1'b0;
  logic       nub_resetn;
  logic [3:0] nub_idn;
  logic [3:0] nub_arbn;
  logic       nub_rqstn;
  logic       arbcy;
  logic       adrcy;
  logic [3:0] arb_oe;
  logic       rqst_oe;
  logic       arb_grant;
  logic       fair_hold;

  nubus_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
    .nub_clkn  (nub_clkn),
    .nub_resetn(nub_resetn),
    .nub_idn   (nub_idn),
    .nub_arbn  (nub_arbn),
    .nub_rqstn (nub_rqstn),
    .arbcy     (arbcy),
    .adrcy     (adrcy),
    .arb_oe    (arb_oe),
    .rqst_oe   (rqst_oe),
    .arb_grant (arb_grant),
    .fair_hold (fair_hold)
  );

  always #5 nub_clkn = ~nub_clkn;

  // Stimulus knobs, applied to the DUT on each falling edge.
  logic [3:0] id_v;
  logic [3:0] other_v;     // wired-OR contribution of the other cards
  logic [3:0] forced_v;    // bus value when the bus is forced
  logic       use_forced;
  logic       rstn_v;
  logic       arbcy_v;
  logic       adrcy_v;
  logic       rqstn_v;

  // Reference model: bus phase of this card plus the history of bus samples
  // taken since arbitration began.
  typedef enum int {M_IDLE, M_ARB, M_GRANT, M_OWN, M_FAIR} phase_t;
  phase_t     ph;
  logic [3:0] hist[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] obs_oe;
  logic       obs_rqst;
  logic       obs_grant;
  logic       obs_hold;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Lines a contender should drive: its ID bits from the MSB down, stopping
  // once a higher bit shows a 1 on the bus that the ID does not have.
  function automatic logic [3:0] contend(input logic [3:0] id, input logic [3:0] bus);
    logic [3:0] oe;
    bit         lost;
    oe   = 4'h0;
    lost = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (id[i] && !lost) oe[i] = 1'b1;
      if (bus[i] && !id[i]) lost = 1'b1;
    end
    return oe;
  endfunction

  // Wired-OR bus value once this card's drive has settled against the others.
  function automatic logic [3:0] resolve(input logic [3:0] id, input logic [3:0] other,
                                         input phase_t p);
    logic [3:0] bus;
    bit         lost;
    bit         drive;
    bus  = other;
    lost = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      drive  = ((p == M_ARB) && id[i] && !lost) || ((p == M_GRANT) && id[i]);
      bus[i] = other[i] | drive;
      if (bus[i] && !id[i]) lost = 1'b1;
    end
    return bus;
  endfunction

  // Settled when the last SETTLE+1 samples all equal the card's ID.
  function automatic bit settled();
    int n;
    n = hist.size();
    if (n < SETTLE + 1) return 1'b0;
    for (int k = n - SETTLE - 1; k < n; k++) begin
      if (hist[k] != id_v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update(input logic [3:0] bus);
    if (!rstn_v) begin
      ph = M_IDLE;
      hist.delete();
    end else begin
      case (ph)
        M_IDLE: if (arbcy_v) begin
          ph = M_ARB;
          hist.delete();
          hist.push_back(bus);
        end
        M_ARB: begin
          if (!arbcy_v) ph = M_IDLE;
          else begin
            hist.push_back(bus);
            if (hist.size() > 12) void'(hist.pop_front());
            if (settled()) ph = M_GRANT;
          end
        end
        M_GRANT: begin
          if (!arbcy_v) ph = FAIR_ON ? M_FAIR : M_IDLE;
          else if (adrcy_v) ph = M_OWN;
        end
        M_OWN:  if (!arbcy_v) ph = FAIR_ON ? M_FAIR : M_IDLE;
        M_FAIR: if (rqstn_v) ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
  endtask

  // Called just after a falling edge. It drives the inputs, checks the
  // current outputs, advances through the rising edge and returns at the
  // next falling edge.
  task automatic step();
    logic [3:0] bus;
    logic [3:0] e_oe;
    nub_resetn = rstn_v;
    arbcy      = arbcy_v;
    adrcy      = adrcy_v;
    nub_rqstn  = rqstn_v;
    nub_idn    = ~id_v;
    bus        = use_forced ? forced_v : resolve(id_v, other_v, ph);
    nub_arbn   = ~bus;
    #1;
    obs_oe    = arb_oe;
    obs_rqst  = rqst_oe;
    obs_grant = arb_grant;
    obs_hold  = fair_hold;
    e_oe = (ph == M_ARB) ? contend(id_v, bus) : (ph == M_GRANT) ? id_v : 4'h0;
    check("arb_oe",    obs_oe,             e_oe);
    check("rqst_oe",   4'(obs_rqst),  4'(ph == M_ARB || ph == M_GRANT));
    check("arb_grant", 4'(obs_grant), 4'(ph == M_GRANT || ph == M_OWN));
    check("fair_hold", 4'(obs_hold),  4'(ph == M_FAIR));
    @(posedge nub_clkn);
    model_update(bus);
    @(negedge nub_clkn);
  endtask

  initial begin
    ph = M_IDLE;
    hist.delete();
    id_v = 4'hA; other_v = 4'h0; forced_v = 4'h0; use_forced = 1'b0;
    rstn_v = 1'b1; arbcy_v = 1'b0; adrcy_v = 1'b0; rqstn_v = 1'b1;

    // Power-on reset.
    nub_resetn = 1'b0; arbcy = 1'b0; adrcy = 1'b0; nub_rqstn = 1'b1;
    nub_idn = ~4'hA; nub_arbn = 4'hF;
    repeat (2) @(posedge nub_clkn);
    @(negedge nub_clkn);
    check("reset_oe",    arb_oe,          4'h0);
    check("reset_rqst",  4'(rqst_oe),     4'h0);
    check("reset_grant", 4'(arb_grant),   4'h0);
    check("reset_hold",  4'(fair_hold),   4'h0);
    step();

    // Uncontested request with ID A.
    arbcy_v = 1'b1;
    step();                                  // cycle 0
    step();                                  // cycle 1
    check("unc_c1_oe",   obs_oe,         4'hA);
    check("unc_c1_rqst", 4'(obs_rqst),   4'h1);
    step(); step();                          // cycles 2,3
    check("unc_c3_grant", 4'(obs_grant), 4'h0);
    step();                                  // cycle 4
    check("unc_c4_grant", 4'(obs_grant), 4'h1);
    adrcy_v = 1'b1;
    step();                                  // cycle 5, adrcy sampled
    adrcy_v = 1'b0;
    step();                                  // cycle 6: OWN
    check("own_oe",    obs_oe,          4'h0);
    check("own_rqst",  4'(obs_rqst),    4'h0);
    check("own_grant", 4'(obs_grant),   4'h1);
    arbcy_v = 1'b0;
    step();                                  // cycle 7, arbcy low sampled
    step();                                  // cycle 8
    check("rel_grant", 4'(obs_grant), 4'h0);
    check("rel_hold",  4'(obs_hold),  4'(FAIR_ON));

    // Fairness gate: /RQST held by others, then released.
    rqstn_v = 1'b0;
    repeat (5) step();
    arbcy_v = 1'b1;
    step();
    step();
    check("fair_hold_on", 4'(obs_hold), 4'(FAIR_ON));
    check("fair_rqst",    4'(obs_rqst), 4'(!FAIR_ON));
    rqstn_v = 1'b1;
    step();
    step();
    check("fair_exit_hold", 4'(obs_hold), 4'h0);
    step();
    check("fair_rearb_rqst", 4'(obs_rqst), 4'h1);
    repeat (3) step();
    check("pre_rst_grant", 4'(obs_grant), 4'h1);

    // Reset during GRANT.
    rstn_v = 1'b0;
    step();
    rstn_v = 1'b1; arbcy_v = 1'b0;
    step();
    check("rst_grant_oe",    obs_oe,        4'h0);
    check("rst_grant_rqst",  4'(obs_rqst),  4'h0);
    check("rst_grant_grant", 4'(obs_grant), 4'h0);
    check("rst_grant_hold",  4'(obs_hold),  4'h0);

    // Contest lost: ID 5 against a winner showing C.
    id_v = 4'h5; other_v = 4'hC; arbcy_v = 1'b1;
    step();
    step();
    check("lose_oe",   obs_oe,        4'h0);
    check("lose_rqst", 4'(obs_rqst),  4'h1);
    repeat (6) step();
    check("lose_grant", 4'(obs_grant), 4'h0);
    other_v = 4'h0;
    step(); step(); step();
    check("win_late_grant0", 4'(obs_grant), 4'h0);
    step();
    check("win_late_grant1", 4'(obs_grant), 4'h1);
    arbcy_v = 1'b0;
    step(); step();

    // Glitchy bus, then a steady one.
    id_v = 4'hA; use_forced = 1'b1; arbcy_v = 1'b1;
    for (int k = 0; k < 10; k++) begin
      forced_v = k[0] ? 4'hB : 4'hA;
      step();
    end
    check("glitch_grant", 4'(obs_grant), 4'h0);
    forced_v = 4'hA;
    step(); step(); step();
    check("steady_grant0", 4'(obs_grant), 4'h0);
    step();
    check("steady_grant1", 4'(obs_grant), 4'h1);
    use_forced = 1'b0; arbcy_v = 1'b0;
    step(); step();
    if (FAIR_ON) begin
      rqstn_v = 1'b1;
      step();
    end

    // Abort in ARB.
    arbcy_v = 1'b1;
    step();                                  // cycle 0
    step();                                  // cycle 1
    arbcy_v = 1'b0;
    step();                                  // cycle 2
    step();                                  // cycle 3
    check("abort_rqst", 4'(obs_rqst), 4'h0);
    check("abort_hold", 4'(obs_hold), 4'h0);

    // Randomized traffic.
    for (int seg = 0; seg < 20; seg++) begin
      id_v = 4'($urandom_range(0, 15));
      other_v = 4'h0; use_forced = 1'b0; arbcy_v = 1'b0; adrcy_v = 1'b0; rqstn_v = 1'b1;
      rstn_v = 1'b0;
      step();
      rstn_v = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if ($urandom_range(0, 11) == 0) arbcy_v = !arbcy_v;
        adrcy_v = ($urandom_range(0, 3) == 0);
        rqstn_v = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 7) == 0)
          other_v = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        use_forced = ($urandom_range(0, 15) == 0);
        forced_v   = 4'($urandom_range(0, 15));
        rstn_v     = ($urandom_range(0, 299) != 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nubus_arbiter.md
# nubus_arbiter

Distributed NuBus arbitration contender for the test card, directly upstream of the master controller. It takes the master's arbitrate request (`arbcy`) and drives the open-collector /RQST and /ARB<3:0> backplane lines using the card's slot ID. It resolves the bitwise priority contest and returns `arb_grant` to the master. An optional fairness gate keeps the card off the bus after its tenure until all other requesters have been served.

## Interface
- `SETTLE_CYCLES`, default 2: number of consecutive clocks the sampled /ARB value must equal own ID before grant. Legal range 1..7.
- `nub_clkn`  in  1  NuBus clock; all state updates on its rising edge.
- `nub_resetn`  in  1  reset. One clock; reset is synchronous and active-low (`nub_clkn`, `nub_resetn`).
- `nub_idn`  in  4  backplane slot ID, active-low. Internal `id = ~nub_idn`.
- `nub_arbn`  in  4  sampled /ARB<3:0> bus, active-low. Internal `arb = ~nub_arbn`.
- `nub_rqstn`  in  1  sampled /RQST bus, active-low.
- `arbcy`  in  1  from master: request bus ownership.
- `adrcy`  in  1  from master: own START cycle being driven.
- `arb_oe`  out  4  per-bit pulldown enable for /ARB<3:0>. 1 = drive line low.
- `rqst_oe`  out  1  pulldown enable for /RQST.
- `arb_grant`  out  1  to master: this card has won arbitration.
- `fair_hold`  out  1  status: fairness gate active.

## Operation
- States: IDLE, ARB, GRANT, OWN, FAIR.
- IDLE: all outputs 0. Go to ARB when `arbcy=1` and (fairness disabled or `fair_hold=0`).
- ARB:
  - `rqst_oe=1`.
  - `arb_oe[3]=id[3]`.
  - `arb_oe[i]=id[i] & AND over j>i of (id[j] | ~arb[j])`, i=2..0. This term is combinational from registered state and the sampled `arb`.
  - Settle counter (3 bits) clears on entry and whenever `arb` differs from its previous-cycle value. It increments while `arb==id`, saturating at 7.
  - Go to GRANT when the counter reaches `SETTLE_CYCLES`.
  - `arbcy=0` returns to IDLE with no fairness hold.
- GRANT: `arb_grant=1`, `rqst_oe=1`, `arb_oe` = ID pattern. Go to OWN on `adrcy=1`. `arbcy=0` goes to FAIR (fairness on) or IDLE.
- OWN: `arb_oe=0`, `rqst_oe=0`, `arb_grant=1`. When `arbcy=0`, go to FAIR (fairness on) or IDLE.
- FAIR: all outputs 0 except `fair_hold=1`. Leave for IDLE on the first cycle `nub_rqstn=1` is sampled.
- A card that loses stays in ARB and keeps contending. Its counter restarts whenever the bus value changes.
- `id=0` is legal. That contender wins only when no other card is driving.

## Timing
- Reset: synchronous. On the first edge with `nub_resetn=0`:
  - state goes to IDLE and the counter clears;
  - `arb_oe=0`, `rqst_oe=0`, `arb_grant=0`, `fair_hold=0`;
  - this applies in every state, including mid-GRANT and mid-OWN.
- `arbcy` rising in IDLE asserts `rqst_oe` and `arb_oe` on the next edge.
- Uncontested latency from `arbcy` rising to `arb_grant=1`: 2 + `SETTLE_CYCLES` edges (1 to enter ARB, 1 for the bus sample, `SETTLE_CYCLES` to settle). With the default this is 4.
- `arb_grant` falls on the edge after `arbcy` is sampled low.
- `adrcy` and `arbcy=0` in the same GRANT cycle: `arbcy=0` has priority.
- FAIR exit requires `nub_rqstn=1` sampled at least one cycle after FAIR is entered.

## Configuration
- `NUBUS_ARB_FAIRNESS_EN` defined: FAIR state and `fair_hold` are active as described above.
- `NUBUS_ARB_FAIRNESS_EN` undefined: all transitions to FAIR go to IDLE instead. `fair_hold` is tied to 0, and IDLE→ARB depends on `arbcy` alone.

## Test plan
- Uncontested: ID=4'hA, bus echoes `arb_oe`, `arbcy`↑ at cycle 0 → `arb_oe=4'hA`, `rqst_oe=1` at cycle 1; `arb_grant=1` at cycle 4; `adrcy` pulse → lines released the next cycle.
- Contest lost: ID=4'h5 against a modelled winner 4'hC (bus=4'hC) → `arb_oe[3]=0`, `arb_oe[2]=0`, `arb_oe[1:0]=0`, `arb_grant` stays 0. When the winner releases (bus follows own drive), grant follows SETTLE cycles later.
- Glitchy bus: bus toggles 4'hA/4'hB on alternate cycles for ID=4'hA → no grant. Bus steady at 4'hA → grant after 2 stable cycles.
- Fairness (macro on): after OWN with `arbcy` dropped and `nub_rqstn=0` held 5 cycles, re-raise `arbcy` → `fair_hold=1`, no `rqst_oe`. Set `nub_rqstn=1` → IDLE, then ARB on the following edge. With the macro off → ARB immediately.
- Reset mid-GRANT: `nub_resetn=0` for 1 cycle → all outputs 0 at that edge. State is IDLE, with no FAIR entered.
- Abort in ARB: `arbcy` drops at cycle 2 → `rqst_oe=0` at cycle 3 and `fair_hold=0`.
